// File: rtl/clock_trigger_decoder.sv
`default_nettype none
// ============================================================================
// Module  : clock_trigger_decoder
// Brief   : Recovers one trigger bit per line period from a duty-cycle-
//           modulated clock (short high = 1, long high = 0).
// Revision: 1.0 - initial release
// ============================================================================
module clock_trigger_decoder #(
   parameter int CNT_W      = 8,
   parameter int MIN_PERIOD = 4,
   parameter int MAX_PERIOD = 64,
   parameter int TIMEOUT    = 128
) (
   input  logic        fastclk,
   input  logic        reset,
   input  logic        line_in,
   output logic        bit_valid,
   output logic        bit_data,
   output logic        frame_err,
   output logic        idle,
   output logic        idle_level,
   output logic [15:0] bit_count
);

   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_M1  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W:0]   MIN_P       = (CNT_W + 1)'(MIN_PERIOD);
   localparam logic [CNT_W:0]   MAX_P       = (CNT_W + 1)'(MAX_PERIOD);

   logic             s1;
   logic             s2;
   logic             s3;
   logic             rise;
   logic             armed;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_next;
   logic [CNT_W-1:0] high_next;
   logic [CNT_W:0]   period_ext;
   logic [CNT_W:0]   high_x2;
   logic             period_ok;

   assign rise = s2 & ~s3;

   // Both counters saturate so a dead line cannot wrap back into a legal period.
   assign period_next = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + CNT_ONE;
   assign high_next   = (s2 && (high_cnt != CNT_MAX)) ? high_cnt + CNT_ONE : high_cnt;

   // The duty comparison is done one bit wider so 2*H never overflows.
   assign period_ext = {1'b0, period_cnt};
   assign high_x2    = {high_cnt, 1'b0};
   assign period_ok  = (period_ext >= MIN_P) && (period_ext <= MAX_P);

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= line_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         period_cnt <= '0;
         high_cnt   <= '0;
      end else if (rise) begin
         period_cnt <= CNT_ONE;
         high_cnt   <= CNT_ONE;
      end else begin
         period_cnt <= period_next;
         high_cnt   <= high_next;
      end
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         armed      <= 1'b0;
         idle       <= 1'b0;
         idle_level <= 1'b0;
      end else if (rise) begin
         armed <= 1'b1;
         idle  <= 1'b0;
      end else if (period_cnt == TIMEOUT_M1) begin
         armed      <= 1'b0;
         idle       <= 1'b1;
         idle_level <= s2;
      end
   end

   // The first rise after reset or idle only opens a measurement window.
   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         bit_valid <= 1'b0;
         bit_data  <= 1'b0;
         frame_err <= 1'b0;
         bit_count <= '0;
      end else begin
         bit_valid <= 1'b0;
         frame_err <= 1'b0;
         if (rise && armed) begin
            if (!period_ok) begin
               frame_err <= 1'b1;
            end else if (high_x2 < period_ext) begin
               bit_valid <= 1'b1;
               bit_data  <= 1'b1;
               bit_count <= bit_count + 16'd1;
            end else if (high_x2 > period_ext) begin
               bit_valid <= 1'b1;
               bit_data  <= 1'b0;
               bit_count <= bit_count + 16'd1;
            end else begin
               frame_err <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/clock_trigger_decoder.md
Name: clock_trigger_decoder

Overview:
- Receive side of the duty-cycle-modulated clock link. Recovers one trigger bit per line period from a clock whose duty cycle carries the bit: short high (below 50%) means trigger=1, long high (above 50%) means trigger=0.
- Oversamples the asynchronous line with a local fast clock. Measures high time and period between consecutive rising edges, and emits a bit, a framing error or an idle indication.
- Sits at the far end of the link and feeds downstream trigger or event logic.

Parameters:
- CNT_W, 8, width of the period and high-time counters; both saturate at 2^CNT_W-1.
- MIN_PERIOD, 4, smallest legal period in fastclk cycles (inclusive).
- MAX_PERIOD, 64, largest legal period in fastclk cycles (inclusive).
- TIMEOUT, 128, fastclk cycles without a rising edge before idle is declared; TIMEOUT > MAX_PERIOD and TIMEOUT < 2^CNT_W-1.

Ports:
- fastclk, input, 1, sampling clock; at least 4x the line frequency.
- reset, input, 1, asynchronous, active-high reset.
- line_in, input, 1, modulated clock from the link; asynchronous to fastclk.
- bit_valid, output, 1, one-cycle pulse; bit_data is valid on this cycle.
- bit_data, output, 1, recovered trigger bit; held until the next bit_valid.
- frame_err, output, 1, one-cycle pulse when a measured period is illegal.
- idle, output, 1, level; the line has shown no rising edge for TIMEOUT cycles.
- idle_level, output, 1, synchronized line level captured when idle asserted (0 = gated-low line, i.e. sustained trigger).
- bit_count, output, 16, count of bit_valid pulses since reset; wraps at 65535 to 0.

Behaviour:
- Reset state: all outputs 0, counters 0, armed 0, synchronizer flops 0. Reset takes effect immediately, including mid-period; any partial measurement is discarded.
- Input path: two-flop synchronizer s1->s2 on posedge fastclk, plus history flop s3. rise = s2 & ~s3 (combinational).
- Counting on each posedge, rise cycle:
  - period_cnt <= 1
  - high_cnt <= 1
- Counting on each posedge, non-rise cycle:
  - period_cnt <= sat(period_cnt+1)
  - high_cnt <= sat(high_cnt+s2)
- Measurement: on a rise cycle with armed=1, P = period_cnt and H = high_cnt (the values before update).
- Classification, registered, visible the cycle after the rise:
  - P < MIN_PERIOD or P > MAX_PERIOD: frame_err=1, bit_valid=0.
  - else 2H < P: bit_valid=1, bit_data=1.
  - else 2H > P: bit_valid=1, bit_data=0.
  - else (2H == P, exact 50%): frame_err=1.
  - 2H is computed at CNT_W+1 bits; no overflow.
- Arming:
  - The first rise after reset or after idle sets armed=1 and produces no bit and no error.
  - Every subsequent rise both measures and keeps armed=1.
- Timeout:
  - On a non-rise cycle where period_cnt == TIMEOUT-1 (counter reaches TIMEOUT): idle<=1, idle_level<=s2, armed<=0.
  - Counter keeps saturating; no further events occur.
- Idle exit: the next rise clears idle on the same clock edge and re-arms. idle_level holds its last value.
- Simultaneous events: rise has priority over timeout. Rise and reset: reset wins.
- Latency: line_in rising edge to bit_valid is 3 or 4 fastclk edges (2-cycle synchronizer, 1 register stage, plus up to 1 cycle of sampling uncertainty).
- bit_count increments on the cycle bit_valid is high.
- Measurements carry ±1 cycle of sampling jitter. The transmitter's 25%/75% encoding keeps a margin of at least 25% of P from the 50% threshold.

Test Plan:
- Reset, then line_in with period 16 cycles and high 4 cycles, repeated 5 times -> first rise produces nothing, then 4 bit_valid pulses with bit_data=1, bit_count=4, frame_err never high.
- Period 16, high 12, 3 periods -> 2 pulses, bit_data=0.
- Alternate high 4 / high 12 on period 16 -> bit_data sequence 1,0,1,0 following the second rise.
- Period 2 (high 1 / low 1), then period 100 -> frame_err pulse for each, no bit_valid. Also period 16 with high exactly 8 -> frame_err.
- Hold line_in low for 200 cycles after valid traffic -> idle=1 within TIMEOUT+3 cycles of the last rise, idle_level=0. Next rise clears idle with no bit; the following rise with high 4 / period 16 gives bit_data=1.
- Assert reset mid-high-phase for 1 cycle -> all outputs 0. The first rise after release yields no bit; bit_count restarts from 0.
